// File: rtl/dbg_cmd_initiator.sv
// Debug command initiator: turns host read/write requests into set-address and data
// commands for a bus master, with an address cache and a per-phase response timeout.
module dbg_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        done_valid,
  output logic [31:0] done_rdata,
  output logic        done_err,
  output logic        cmd_stb,
  output logic [33:0] cmd_word,
  input  logic        cmd_busy,
  input  logic        rsp_stb,
  input  logic [33:0] rsp_word
);

  typedef enum logic [2:0] {
    IDLE, ADDR_CMD, ADDR_WAIT, DATA_CMD, DATA_WAIT, DONE
  } state_t;

  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        lat_write;
  logic [29:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [29:0] cache_addr;
  logic        cache_vld;
  logic [15:0] tcnt;
  logic [1:0]  rsp_code;
  logic [1:0]  data_expect;
  logic        unused_addr_bits;

  function automatic logic [33:0] addr_cmd(input logic [29:0] word_addr);
    return {2'b10, 1'b0, 1'b1, word_addr};
  endfunction

  function automatic logic [33:0] data_cmd(input logic write, input logic [31:0] wdata);
    return write ? {2'b01, wdata} : {2'b00, 32'h0};
  endfunction

  assign rsp_code         = rsp_word[33:32];
  assign data_expect      = lat_write ? 2'b00 : 2'b01;
  assign req_ready        = (state == IDLE);
  assign unused_addr_bits = ^req_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cache_addr <= '0;
      cache_vld  <= 1'b0;
      tcnt       <= '0;
      cmd_stb    <= 1'b0;
      cmd_word   <= '0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      done_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr[31:2];
            lat_wdata <= req_wdata;
            cmd_stb   <= 1'b1;
            // A cached address lets the data command go out directly.
            if (!cache_vld || cache_addr != req_addr[31:2]) begin
              state    <= ADDR_CMD;
              cmd_word <= addr_cmd(req_addr[31:2]);
            end else begin
              state    <= DATA_CMD;
              cmd_word <= data_cmd(req_write, req_wdata);
            end
          end
        end
        ADDR_CMD: begin
          if (!cmd_busy) begin
            cmd_stb <= 1'b0;
            tcnt    <= '0;
            state   <= ADDR_WAIT;
          end
        end
        ADDR_WAIT: begin
          if (rsp_stb && rsp_code == 2'b10) begin
            cache_addr <= lat_addr;
            cache_vld  <= 1'b1;
            cmd_word   <= data_cmd(lat_write, lat_wdata);
            cmd_stb    <= 1'b1;
            state      <= DATA_CMD;
          end else if ((rsp_stb && rsp_code == 2'b11) || tcnt == TCNT_LAST) begin
            cache_vld  <= 1'b0;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DATA_CMD: begin
          if (!cmd_busy) begin
            cmd_stb <= 1'b0;
            tcnt    <= '0;
            state   <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (rsp_stb && rsp_code == data_expect) begin
            if (!lat_write) done_rdata <= rsp_word[31:0];
            done_valid <= 1'b1;
            done_err   <= 1'b0;
            state      <= DONE;
          end else if ((rsp_stb && rsp_code == 2'b11) || tcnt == TCNT_LAST) begin
            cache_vld  <= 1'b0;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DONE: begin
          done_valid <= 1'b0;
          done_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_cmd_initiator.sv
// Bench for dbg_cmd_initiator: directed scenarios then randomized transactions,
// with a bus-master responder and an address-cache/read-data reference model.
module tb_dbg_cmd_initiator;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic        done_err;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy = 1'b1;
  logic        rsp_stb = 1'b0;
  logic [33:0] rsp_word = '0;

  int checks = 0;
  int errors = 0;
  int cmd_acc = 0;
  int done_cnt = 0;

  bit          m_cvalid;
  logic [29:0] m_caddr;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dbg_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .done_valid(done_valid), .done_rdata(done_rdata), .done_err(done_err),
    .cmd_stb(cmd_stb), .cmd_word(cmd_word), .cmd_busy(cmd_busy),
    .rsp_stb(rsp_stb), .rsp_word(rsp_word)
  );

  always @(posedge clk) begin
    if (reset && cmd_stb && !cmd_busy) cmd_acc <= cmd_acc + 1;
    if (done_valid) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    req_valid = 1'b0;
    rsp_stb   = 1'b0;
  endtask

  // Plays the bus master for one command: busy for busy_n cycles, then accepts,
  // then answers after delay cycles (or never, when tmo is set).
  task automatic phase(input logic [33:0] exp_word, input int busy_n, input bit tmo,
                       input logic [1:0] code, input logic [31:0] data, input int delay,
                       input bit junk, input logic [1:0] junk_code);
    int lim;
    step();
    chk("stb_rise", 34'(cmd_stb), 34'd1);
    for (int w = 0; w < 4 && !cmd_stb; w++) step();
    chk("cmd_word", cmd_word, exp_word);
    for (int i = 0; i <= busy_n; i++) begin
      if (i > 0) begin
        step();
        chk("stb_hold", 34'(cmd_stb), 34'd1);
        chk("word_hold", cmd_word, exp_word);
      end
      cmd_busy = (i < busy_n);
    end
    if (junk) begin
      rsp_stb  = 1'b1;
      rsp_word = {2'b11, 32'($urandom)};
    end
    lim = tmo ? T : delay;
    for (int k = 1; k <= lim; k++) begin
      step();
      cmd_busy = 1'b1;
      if (k == 1) chk("stb_drop", 34'(cmd_stb), 34'd0);
      if (!tmo && k == delay) begin
        rsp_stb  = 1'b1;
        rsp_word = {code, data};
      end else if (junk && k == 1) begin
        rsp_stb  = 1'b1;
        rsp_word = {junk_code, 32'($urandom)};
      end
    end
  endtask

  // amode/dmode: 0 = expected ack, 1 = bus error, 2 = no response (timeout)
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int busy_n, input int amode, input int dmode,
                     input logic [31:0] rdat, input int adelay, input int ddelay, input bit junk);
    int  acc0, dn0, ncmd;
    bit  err;
    bit  need;
    logic [1:0] jc;
    step();
    chk("ready_idle", 34'(req_ready), 34'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    acc0 = cmd_acc;
    dn0  = done_cnt;
    ncmd = 0;
    err  = 1'b0;
    need = !m_cvalid || (m_caddr != addr[31:2]);
    if (need) begin
      jc = $urandom_range(0, 1) ? 2'b01 : 2'b00;
      phase({2'b10, 2'b01, addr[31:2]}, busy_n, amode == 2, (amode == 1) ? 2'b11 : 2'b10,
            32'($urandom), adelay, junk, jc);
      ncmd++;
      if (amode == 0) begin
        m_cvalid = 1'b1;
        m_caddr  = addr[31:2];
      end else begin
        err      = 1'b1;
        m_cvalid = 1'b0;
      end
    end
    if (!err) begin
      if (wr) jc = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      else    jc = $urandom_range(0, 1) ? 2'b00 : 2'b10;
      phase(wr ? {2'b01, wd} : 34'h0, busy_n, dmode == 2,
            (dmode == 1) ? 2'b11 : (wr ? 2'b00 : 2'b01), rdat, ddelay, junk, jc);
      ncmd++;
      if (dmode != 0) begin
        err      = 1'b1;
        m_cvalid = 1'b0;
      end else if (!wr) begin
        m_rdata = rdat;
      end
    end
    step();
    chk("done_valid", 34'(done_valid), 34'd1);
    chk("done_err", 34'(done_err), 34'(err));
    chk("done_rdata", 34'(done_rdata), 34'(m_rdata));
    chk("ready_done", 34'(req_ready), 34'd0);
    step();
    chk("done_drop", 34'(done_valid), 34'd0);
    chk("err_idle", 34'(done_err), 34'd0);
    chk("ready_back", 34'(req_ready), 34'd1);
    chk("done_pulses", 34'(done_cnt - dn0), 34'd1);
    chk("cmd_accepts", 34'(cmd_acc - acc0), 34'(ncmd));
  endtask

  initial begin
    logic [31:0] addrs [4];
    int dn;
    int r;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h10; addrs[3] = 32'h104;
    m_cvalid = 1'b0;
    m_caddr  = '0;
    m_rdata  = '0;

    repeat (3) @(negedge clk);
    chk("rst_stb", 34'(cmd_stb), 34'd0);
    chk("rst_word", cmd_word, 34'd0);
    chk("rst_done", 34'(done_valid), 34'd0);
    chk("rst_err", 34'(done_err), 34'd0);
    chk("rst_rdata", 34'(done_rdata), 34'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_stb", 34'(cmd_stb), 34'd0);
      chk("idle_done", 34'(done_valid), 34'd0);
      chk("idle_ready", 34'(req_ready), 34'd1);
    end

    txn(1'b1, 32'h0, 32'hAABBCCDD, 0, 0, 0, 32'h0, 1, 2, 1'b0);
    txn(1'b0, 32'h0, 32'h0, 0, 0, 0, 32'h12345678, 1, 1, 1'b0);
    txn(1'b1, 32'h200, 32'hCAFEF00D, 3, 0, 0, 32'h0, 2, 3, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 0, 0, 2, 32'h0, 1, 1, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 0, 0, 0, 32'h0BADBEEF, 1, 4, 1'b0);

    step();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h5555AAAA;
    step();
    chk("mid_stb", 34'(cmd_stb), 34'd1);
    chk("mid_word", cmd_word, {2'b01, 32'h5555AAAA});
    cmd_busy = 1'b0;
    step();
    cmd_busy = 1'b1;
    chk("mid_wait", 34'(cmd_stb), 34'd0);
    dn = done_cnt;
    step();
    #2 reset = 1'b0;
    #1;
    chk("async_stb", 34'(cmd_stb), 34'd0);
    chk("async_word", cmd_word, 34'd0);
    chk("async_rdata", 34'(done_rdata), 34'd0);
    chk("async_ready", 34'(req_ready), 34'd1);
    m_cvalid = 1'b0;
    m_rdata  = '0;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("abort_no_done", 34'(done_cnt - dn), 34'd0);
    txn(1'b1, 32'h10, 32'h01020304, 1, 0, 0, 32'h0, 1, 1, 1'b0);

    txn(1'b0, 32'h40, 32'h0, 0, 1, 0, 32'h0, 3, 1, 1'b0);
    txn(1'b0, 32'h40, 32'h0, 1, 2, 0, 32'h0, 1, 1, 1'b0);
    txn(1'b0, 32'h44, 32'h0, 2, 0, 0, 32'h77665544, 3, 4, 1'b1);
    txn(1'b1, 32'h44, 32'h99, 0, 0, 1, 32'h0, 1, 2, 1'b1);

    for (int n = 0; n < 30; n++) begin
      int am, dm;
      r  = $urandom_range(0, 9);
      am = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
      r  = $urandom_range(0, 9);
      dm = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
      txn(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
          32'($urandom), $urandom_range(0, 3), am, dm, 32'($urandom),
          $urandom_range(1, T - 2), $urandom_range(1, T - 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
